// File: rtl/profiler_pkg.sv
// rtl/profiler_pkg.sv - shared constants and readout state encoding for the state profiler
package profiler_pkg;

  localparam int DEF_NUM_STATES   = 8;
  localparam int DEF_SEL_W        = 3;
  localparam int DEF_COUNT_W      = 32;
  localparam int DEF_DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    RD_IDLE    = 3'd0,
    RD_RUN     = 3'd1,
    RD_DRAIN   = 3'd2,
    RD_SETTLE  = 3'd3,
    RD_CAPTURE = 3'd4,
    RD_SEND    = 3'd5,
    RD_DONE    = 3'd6
  } readout_state_e;

endpackage

// File: rtl/profile_readout.sv
// rtl/profile_readout.sv - runs the state profiler and streams its per-state counts to the host
module profile_readout
  import profiler_pkg::*;
#(
  parameter int NUM_STATES   = DEF_NUM_STATES,
  parameter int SEL_W        = DEF_SEL_W,
  parameter int COUNT_W      = DEF_COUNT_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               io_enable,
  input  logic               io_dump,
  output logic               io_prof_start,
  output logic [SEL_W-1:0]   io_prof_sel,
  input  logic [COUNT_W-1:0] io_prof_count,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [COUNT_W-1:0] io_out_bits,
  output logic [SEL_W-1:0]   io_out_index,
  output logic               io_out_last,
  output logic               io_busy,
  output logic               io_done
);

  // Drain counter holds DRAIN_CYCLES-1 down to 0, so one bit minimum.
  localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [SEL_W-1:0]   LAST_IDX   = SEL_W'(NUM_STATES - 1);

  logic [1:0]         rst_sync;
  logic               rst_n;

  readout_state_e     state, state_n;
  logic [DRAIN_W-1:0] drain_cnt, drain_n;
  logic [SEL_W-1:0]   idx, idx_n;
  logic               start_q, start_n;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic               valid_q, valid_n;
  logic [COUNT_W-1:0] bits_q, bits_n;
  logic [SEL_W-1:0]   index_q, index_n;
  logic               last_q, last_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;

  // Reset synchronizer: assertion passes straight through, release is aligned to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // State, counters and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RD_IDLE;
      drain_cnt <= '0;
      idx       <= '0;
      start_q   <= 1'b0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      bits_q    <= '0;
      index_q   <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_n;
      idx       <= idx_n;
      start_q   <= start_n;
      sel_q     <= sel_n;
      valid_q   <= valid_n;
      bits_q    <= bits_n;
      index_q   <= index_n;
      last_q    <= last_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  // Next state and next registered outputs; dump is only honoured from IDLE and RUN.
  always_comb begin
    state_n = state;
    drain_n = drain_cnt;
    idx_n   = idx;
    start_n = 1'b0;
    sel_n   = sel_q;
    valid_n = valid_q;
    bits_n  = bits_q;
    index_n = index_q;
    last_n  = last_q;
    done_n  = 1'b0;

    case (state)
      RD_IDLE: begin
        sel_n = '0;
        if (io_dump) begin
          state_n = RD_DRAIN;
          drain_n = DRAIN_LOAD;
        end else if (io_enable) begin
          state_n = RD_RUN;
          start_n = 1'b1;
        end
      end
      RD_RUN: begin
        if (io_dump || !io_enable) begin
          state_n = RD_DRAIN;
          drain_n = DRAIN_LOAD;
        end else begin
          start_n = 1'b1;
        end
      end
      RD_DRAIN: begin
        // Give the profiler time to finish its trailing count before reading.
        if (drain_cnt == '0) begin
          state_n = RD_SETTLE;
          idx_n   = '0;
          sel_n   = '0;
        end else begin
          drain_n = drain_cnt - 1'b1;
        end
      end
      RD_SETTLE: begin
        state_n = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        bits_n  = io_prof_count;
        index_n = idx;
        last_n  = (idx == LAST_IDX);
        valid_n = 1'b1;
        state_n = RD_SEND;
      end
      RD_SEND: begin
        if (io_out_ready) begin
          valid_n = 1'b0;
          if (last_q) begin
            state_n = RD_DONE;
            done_n  = 1'b1;
          end else begin
            idx_n   = idx + 1'b1;
            sel_n   = idx + 1'b1;
            state_n = RD_SETTLE;
          end
        end
      end
      RD_DONE: begin
        sel_n   = '0;
        state_n = RD_IDLE;
      end
      default: begin
        state_n = RD_IDLE;
      end
    endcase

    busy_n = (state_n != RD_IDLE);
  end

  assign io_prof_start = start_q;
  assign io_prof_sel   = sel_q;
  assign io_out_valid  = valid_q;
  assign io_out_bits   = bits_q;
  assign io_out_index  = index_q;
  assign io_out_last   = last_q;
  assign io_busy       = busy_q;
  assign io_done       = done_q;

endmodule

// File: tb/tb_profile_readout.sv
// tb/tb_profile_readout.sv - scoreboard bench for profile_readout with a profiler model
module tb_profile_readout;
  import profiler_pkg::*;

  localparam int NS = 8;
  localparam int SW = 3;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          io_enable = 1'b0;
  logic          io_dump = 1'b0;
  logic          io_out_ready = 1'b0;
  logic          io_prof_start;
  logic [SW-1:0] io_prof_sel;
  logic [CW-1:0] io_prof_count;
  logic          io_out_valid;
  logic [CW-1:0] io_out_bits;
  logic [SW-1:0] io_out_index;
  logic          io_out_last;
  logic          io_busy;
  logic          io_done;

  always #5 clk = ~clk;

  profile_readout dut (
    .clk           (clk),
    .reset         (reset),
    .io_enable     (io_enable),
    .io_dump       (io_dump),
    .io_prof_start (io_prof_start),
    .io_prof_sel   (io_prof_sel),
    .io_prof_count (io_prof_count),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_bits   (io_out_bits),
    .io_out_index  (io_out_index),
    .io_out_last   (io_out_last),
    .io_busy       (io_busy),
    .io_done       (io_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Profiler model: clears on start rising, counts the registered probe while
  // start is high and for one cycle after it falls.
  logic [CW-1:0] prof_cnt [NS];
  logic          start_q;
  logic [SW-1:0] probe = '0;
  logic [SW-1:0] probe_q;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NS; i++) prof_cnt[i] <= '0;
      start_q <= 1'b0;
      probe_q <= '0;
    end else begin
      start_q <= io_prof_start;
      probe_q <= probe;
      if (io_prof_start && !start_q) begin
        for (int i = 0; i < NS; i++) prof_cnt[i] <= '0;
        prof_cnt[probe_q] <= 1;
      end else if (io_prof_start || start_q) begin
        prof_cnt[probe_q] <= prof_cnt[probe_q] + 1;
      end
    end
  end

  assign io_prof_count = prof_cnt[io_prof_sel];

  // Host ready: 0 = always high, 1 = high 30% of cycles.
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) io_out_ready = 1'b1;
    else                 io_out_ready = ($urandom_range(0, 99) < 30);
  end

  typedef struct {
    logic [CW-1:0] bits;
    logic [SW-1:0] index;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  word_t         w;
  logic [CW-1:0] got [NS];
  logic          held_v = 1'b0;
  logic [CW-1:0] held_bits;
  logic [SW-1:0] held_idx;
  logic          held_last;
  int            last_hs_cyc = 0;
  bit            spacing_on = 1'b0;
  bit            start_forbidden = 1'b0;
  int            hs_cnt = 0;
  int            done_cnt = 0;
  int            start_cycles = 0;

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      held_v = 1'b0;
    end else begin
      if (io_prof_start) start_cycles++;
      if (start_forbidden) chk("prof_start_during_idle_dump", io_prof_start, 0);
      if (io_done) done_cnt++;
      if (held_v) begin
        chk("stall_valid", io_out_valid, 1);
        chk("stall_bits", io_out_bits, held_bits);
        chk("stall_index", io_out_index, held_idx);
        chk("stall_last", io_out_last, held_last);
      end
      held_v = 1'b0;
      if (io_out_valid) begin
        chk("last_flag", io_out_last, (io_out_index == SW'(NS - 1)));
        if (io_out_ready) begin
          hs_cnt++;
          got[io_out_index] = io_out_bits;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got index %0d expected no word", io_out_index);
          end else begin
            w = exp_q.pop_front();
            chk("word_bits", io_out_bits, w.bits);
            chk("word_index", io_out_index, w.index);
            chk("word_last", io_out_last, w.last);
          end
          if (spacing_on && io_out_index != 0) chk("word_spacing", cyc - last_hs_cyc, 3);
          last_hs_cyc = cyc;
        end else begin
          held_v    = 1'b1;
          held_bits = io_out_bits;
          held_idx  = io_out_index;
          held_last = io_out_last;
        end
      end
    end
  end

  function automatic logic [SW-1:0] pick(input int pmode, input int i);
    if (pmode == 0) return SW'(2);
    if (pmode == 1) return (i % 2 == 1) ? SW'(6) : SW'(5);
    return SW'($urandom_range(0, NS - 1));
  endfunction

  task automatic push_expected();
    for (int i = 0; i < NS; i++) begin
      word_t e;
      e.bits  = prof_cnt[i];
      e.index = SW'(i);
      e.last  = (i == NS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input bit settle);
    int t = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done pulse expected one", name);
    end
    if (settle) begin
      repeat (4) @(negedge clk);
      chk({name, "_done_once"}, done_cnt - d0, 1);
      chk({name, "_queue_drained"}, exp_q.size(), 0);
      chk({name, "_busy_clear"}, io_busy, 0);
    end
  endtask

  // Enable for n cycles, then drop enable (optionally with a dump pulse).
  task automatic do_run(input int n, input int pmode, input bit use_dump);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      io_enable = 1'b1;
      probe = pick(pmode, i);
    end
    @(negedge clk);
    io_enable = 1'b0;
    io_dump = use_dump;
    probe = pick(pmode, n);
    @(negedge clk);
    io_dump = 1'b0;
    probe = pick(pmode, n + 1);
    repeat (2) @(negedge clk);
    push_expected();
  endtask

  initial begin
    int h0;
    int s0;
    int found;
    int seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_prof_start", io_prof_start, 0);
    chk("rst_prof_sel", io_prof_sel, 0);
    chk("rst_out_valid", io_out_valid, 0);
    chk("rst_out_bits", io_out_bits, 0);
    chk("rst_out_index", io_out_index, 0);
    chk("rst_out_last", io_out_last, 0);
    chk("rst_busy", io_busy, 0);
    chk("rst_done", io_done, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Dump from IDLE after reset: eight zero words, no start
    ready_mode = 0;
    start_forbidden = 1'b1;
    h0 = hs_cnt;
    io_dump = 1'b1;
    @(negedge clk);
    io_dump = 1'b0;
    repeat (3) @(negedge clk);
    push_expected();
    wait_done("idle_dump", 1'b1);
    chk("idle_dump_words", hs_cnt - h0, 8);

    // Dump and enable together: dump wins, enable retriggers only after DONE
    h0 = hs_cnt;
    io_dump = 1'b1;
    io_enable = 1'b1;
    @(negedge clk);
    io_dump = 1'b0;
    repeat (3) @(negedge clk);
    push_expected();
    wait_done("dump_enable", 1'b0);
    start_forbidden = 1'b0;
    chk("dump_enable_words", hs_cnt - h0, 8);
    seen = 0;
    for (int t = 0; t < 5 && seen == 0; t++) begin
      @(negedge clk);
      if (io_prof_start) seen = 1;
    end
    chk("retrigger_run", seen, 1);
    do_run(20, 2, 1'b0);
    wait_done("retrigger", 1'b1);

    // Fixed probe 2 for 100 cycles then dump
    h0 = hs_cnt;
    s0 = start_cycles;
    do_run(100, 0, 1'b1);
    wait_done("fixed_probe", 1'b1);
    chk("fixed_start_cycles", start_cycles - s0, 100);
    chk("fixed_words", hs_cnt - h0, 8);
    chk("fixed_word2", got[2], 101);
    chk("fixed_word0", got[0], 0);

    // Alternating probe 5/6 for 40 cycles, ready high, 3-cycle spacing
    spacing_on = 1'b1;
    h0 = hs_cnt;
    do_run(40, 1, 1'b0);
    wait_done("alternating", 1'b1);
    spacing_on = 1'b0;
    chk("alt_sum56", got[5] + got[6], 41);
    chk("alt_words", hs_cnt - h0, 8);

    // Random probe with 30% ready backpressure
    ready_mode = 1;
    h0 = hs_cnt;
    do_run(60, 2, 1'b1);
    wait_done("backpressure", 1'b1);
    chk("bp_words", hs_cnt - h0, 8);

    // Dump pulses and enable toggles during SEND are ignored
    ready_mode = 0;
    h0 = hs_cnt;
    do_run(30, 2, 1'b1);
    found = 0;
    for (int t = 0; t < 50 && found == 0; t++) begin
      @(negedge clk);
      if (io_out_valid) found = 1;
    end
    chk("ignore_reach_send", found, 1);
    for (int k = 0; k < 6; k++) begin
      io_dump = 1'b1;
      io_enable = ~io_enable;
      @(negedge clk);
      io_dump = 1'b0;
      @(negedge clk);
    end
    io_enable = 1'b0;
    wait_done("ignore", 1'b1);
    chk("ignore_words", hs_cnt - h0, 8);

    // Reset during SEND at index 4
    ready_mode = 1;
    do_run(30, 2, 1'b0);
    found = 0;
    for (int t = 0; t < 1000 && found == 0; t++) begin
      @(negedge clk);
      if (io_out_valid && io_out_index == 4) found = 1;
    end
    chk("reach_index4", found, 1);
    reset = 1'b0;
    #1;
    chk("midsend_valid_drop", io_out_valid, 0);
    chk("midsend_busy_drop", io_busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (io_out_valid || io_busy || io_prof_start) seen = 1;
    end
    chk("idle_after_reset", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
